inet_checksum: RTL

Parametrised Internet (RFC 1071) one's-complement checksum engine for UDP/TCP/IPv4 header paths. It consumes one AXI-Stream packet of any byte length, 2 to 16 bytes per beat, with tkeep byte masking. It adds an optional 16-bit seed (pre-summed pseudo-header) and emits one checksum result per packet. The result carries a verify flag for the receive path and optional UDP zero-substitution.

---
 rtl/inet_csum_pkg.sv | 15 +
 rtl/csum_lane_fold.sv | 44 ++++
 rtl/inet_checksum.sv | 106 ++++++++++
 3 files changed

// File: rtl/inet_csum_pkg.sv
// rtl/inet_csum_pkg.sv - shared types and helpers for the Internet checksum engine
package inet_csum_pkg;

   // Bit n set means an input beat of n bytes is supported.
   localparam logic [16:0] LEGAL_AXIS_BYTES = 17'h10114;

   typedef enum logic [2:0] {IDLE, ACC, NORM, FOLD, OUT} csum_state_t;

   function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/csum_lane_fold.sv
// rtl/csum_lane_fold.sv - registered binary one's-complement fold of LANES 16-bit values
module csum_lane_fold
   import inet_csum_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 i_start,
   input  logic                 i_step,
   input  logic [LANES*16-1:0]  i_lanes,
   output logic                 o_last,
   output logic [15:0]          o_sum
);
   localparam int L  = $clog2(LANES);
   localparam int LW = (L > 0) ? $clog2(L + 1) : 1;

   logic [15:0]   r_val [LANES];
   logic [LW-1:0] r_lvl;
   logic [31:0]   w_half;

   always_comb w_half = 32'(LANES) >> (32'(r_lvl) + 32'd1);

   // Each step halves the live lane count; lane 0 ends up holding the full sum.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_lvl <= '0;
         for (int j = 0; j < LANES; j++) r_val[j] <= '0;
      end else if (i_start) begin
         r_lvl <= '0;
         for (int j = 0; j < LANES; j++) r_val[j] <= i_lanes[16*j +: 16];
      end else if (i_step) begin
         r_lvl <= r_lvl + LW'(1);
         for (int j = 0; j < LANES; j++) begin
            if (32'(j) < w_half)
               r_val[j] <= ones_add16(r_val[j], r_val[(j + int'(w_half)) % LANES]);
         end
      end
   end

   assign o_last = (r_lvl == LW'(L - 1));
   assign o_sum  = r_val[0];

endmodule

// File: rtl/inet_checksum.sv
// rtl/inet_checksum.sv - RFC 1071 checksum over one AXI-Stream packet with seed and verify flag
module inet_checksum
   import inet_csum_pkg::*;
#(
   parameter int AXIS_BYTES   = 2,
   parameter bit UDP_ZERO_SUB = 1'b0
) (
   input  logic                    clk,
   input  logic                    aresetn,
   output logic                    axis_i_tready,
   input  logic                    axis_i_tvalid,
   input  logic                    axis_i_tlast,
   input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
   input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
   input  logic [15:0]             axis_i_seed,
   input  logic                    axis_o_tready,
   output logic                    axis_o_tvalid,
   output logic [15:0]             axis_o_csum,
   output logic                    axis_o_ok
);
   localparam int LANES = AXIS_BYTES / 2;
   localparam int L     = $clog2(LANES);

   if ((AXIS_BYTES > 16) || !LEGAL_AXIS_BYTES[AXIS_BYTES]) begin : g_bad_width
      $error("inet_checksum: AXIS_BYTES must be 2, 4, 8 or 16");
   end

   csum_state_t             r_state, w_next;
   logic [16:0]             r_acc [LANES];
   logic [AXIS_BYTES*8-1:0] w_masked;
   logic [LANES*16-1:0]     w_norm;
   logic                    w_in_fire, w_out_fire, w_fold_last;
   logic [15:0]             w_sum, w_csum;

   always_comb begin
      w_masked = '0;
      for (int k = 0; k < AXIS_BYTES; k++)
         w_masked[8*k +: 8] = axis_i_tkeep[k] ? axis_i_tdata[8*k +: 8] : 8'h00;
   end

   assign w_in_fire  = axis_i_tvalid & axis_i_tready;
   assign w_out_fire = axis_o_tvalid & axis_o_tready;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, ACC: if (w_in_fire) w_next = axis_i_tlast ? NORM : ACC;
         NORM:      w_next = (L > 0) ? FOLD : OUT;
         FOLD:      if (w_fold_last) w_next = OUT;
         OUT:       if (w_out_fire) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      axis_i_tready = 1'b0;
      axis_o_tvalid = 1'b0;
      case (r_state)
         IDLE, ACC: axis_i_tready = 1'b1;
         OUT:       axis_o_tvalid = 1'b1;
         default:   ;
      endcase
   end

   // Lane sums stay within 17 bits: the carry is folded back in on every later beat.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int j = 0; j < LANES; j++) r_acc[j] <= '0;
      end else if (w_in_fire) begin
         for (int j = 0; j < LANES; j++) begin
            if (r_state == IDLE)
               r_acc[j] <= {1'b0, w_masked[16*j +: 16]} + ((j == 0) ? {1'b0, axis_i_seed} : 17'd0);
            else
               r_acc[j] <= {1'b0, w_masked[16*j +: 16]} + {1'b0, r_acc[j][15:0]} + {16'd0, r_acc[j][16]};
         end
      end else if (w_out_fire) begin
         for (int j = 0; j < LANES; j++) r_acc[j] <= '0;
      end
   end

   always_comb begin
      w_norm = '0;
      for (int j = 0; j < LANES; j++)
         w_norm[16*j +: 16] = r_acc[j][15:0] + {15'd0, r_acc[j][16]};
   end

   csum_lane_fold #(.LANES(LANES)) u_fold (
      .clk     (clk),
      .aresetn (aresetn),
      .i_start (r_state == NORM),
      .i_step  (r_state == FOLD),
      .i_lanes (w_norm),
      .o_last  (w_fold_last),
      .o_sum   (w_sum)
   );

   assign w_csum      = ~w_sum;
   assign axis_o_csum = (UDP_ZERO_SUB && (w_csum == 16'h0000)) ? 16'hFFFF : w_csum;
   assign axis_o_ok   = (w_sum == 16'hFFFF);

endmodule
